// File: rtl/lockstep_cmp_pkg.sv
// Shared definitions for the lockstep comparator: run-state encoding and
// the compare-mode selector values.
package lockstep_cmp_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  localparam int MODE_EXACT = 0;
  localparam int MODE_SPECX = 1;

endpackage

// File: rtl/lockstep_cmp_chan.sv
// One channel of the lockstep compare: flags a mismatch between the
// reference and implementation values of a single WIDTH-bit channel.
module lockstep_cmp_chan
  import lockstep_cmp_pkg::*;
#(
  parameter int WIDTH = 4,
  parameter int MODE  = MODE_EXACT
) (
  input  logic [WIDTH-1:0] spec,
  input  logic [WIDTH-1:0] impl,
  output logic             mismatch
);

  // A spec bit that is neither 0 nor 1 is X or Z; MODE_SPECX treats it as don't-care.
  always_comb begin
    mismatch = 1'b0;
    for (int unsigned i = 0; i < WIDTH; i++) begin
      if (spec[i] !== impl[i]) begin
        if ((MODE == MODE_EXACT) || (spec[i] === 1'b0) || (spec[i] === 1'b1)) begin
          mismatch = 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/lockstep_cmp.sv
// Lockstep comparator: compares NCH reference/implementation channels per
// sample during a start/stop run, counting samples and failing samples.
module lockstep_cmp
  import lockstep_cmp_pkg::*;
#(
  parameter int WIDTH = 4,
  parameter int NCH   = 6,
  parameter int TAGW  = 8,
  parameter int CNTW  = 16,
  parameter int MODE  = MODE_EXACT,
  localparam int CHW  = (NCH > 1) ? $clog2(NCH) : 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic                 stop,
  input  logic                 sample_valid,
  input  logic [NCH*WIDTH-1:0] spec_bus,
  input  logic [NCH*WIDTH-1:0] impl_bus,
  input  logic [TAGW-1:0]      tag,
  output logic                 busy,
  output logic                 done,
  output logic                 pass,
  output logic [NCH-1:0]       mismatch_mask,
  output logic [CNTW-1:0]      sample_cnt,
  output logic [CNTW-1:0]      fail_cnt,
  output logic [CHW-1:0]       first_ch,
  output logic [TAGW-1:0]      first_tag,
  output logic [WIDTH-1:0]     first_spec,
  output logic [WIDTH-1:0]     first_impl
);

  state_t state, next_state;

  logic [NCH-1:0]   chan_mm;
  logic [CHW-1:0]   low_idx;
  logic [WIDTH-1:0] low_spec;
  logic [WIDTH-1:0] low_impl;
  logic             enter_run;
  logic             take;

  for (genvar k = 0; k < NCH; k++) begin : g_chan
    lockstep_cmp_chan #(
      .WIDTH (WIDTH),
      .MODE  (MODE)
    ) u_chan (
      .spec     (spec_bus[k*WIDTH +: WIDTH]),
      .impl     (impl_bus[k*WIDTH +: WIDTH]),
      .mismatch (chan_mm[k])
    );
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= ST_IDLE;
    else     state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      ST_IDLE: if (start) next_state = ST_RUN;
      ST_RUN:  if (stop)  next_state = ST_DONE;
      ST_DONE: if (start) next_state = ST_RUN;
      default: next_state = ST_IDLE;
    endcase
  end

  assign busy      = (state == ST_RUN);
  assign done      = (state == ST_DONE);
  assign pass      = done && (fail_cnt == '0);
  assign enter_run = (state != ST_RUN) && (next_state == ST_RUN);
  assign take      = (state == ST_RUN) && sample_valid;

  // Lowest failing channel and its values, for first-failure capture.
  always_comb begin
    logic found;
    found    = 1'b0;
    low_idx  = '0;
    low_spec = '0;
    low_impl = '0;
    for (int unsigned k = 0; k < NCH; k++) begin
      if (chan_mm[k] && !found) begin
        found    = 1'b1;
        low_idx  = CHW'(k);
        low_spec = spec_bus[k*WIDTH +: WIDTH];
        low_impl = impl_bus[k*WIDTH +: WIDTH];
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mismatch_mask <= '0;
      sample_cnt    <= '0;
      fail_cnt      <= '0;
      first_ch      <= '0;
      first_tag     <= '0;
      first_spec    <= '0;
      first_impl    <= '0;
    end else if (enter_run) begin
      mismatch_mask <= '0;
      sample_cnt    <= '0;
      fail_cnt      <= '0;
      first_ch      <= '0;
      first_tag     <= '0;
      first_spec    <= '0;
      first_impl    <= '0;
    end else if (take) begin
      mismatch_mask <= chan_mm;
      if (sample_cnt != '1) sample_cnt <= sample_cnt + CNTW'(1);
      if (|chan_mm) begin
        if (fail_cnt != '1) fail_cnt <= fail_cnt + CNTW'(1);
        // fail_cnt never returns to zero within a run, so zero marks the first failure.
        if (fail_cnt == '0) begin
          first_ch   <= low_idx;
          first_tag  <= tag;
          first_spec <= low_spec;
          first_impl <= low_impl;
        end
      end
    end
  end

endmodule

// File: tb/tb_lockstep_cmp.sv
// Self-checking bench for lockstep_cmp: three instances (exact, spec-X
// don't-care, 2-bit counters) driven by shared stimulus.
module tb_lockstep_cmp;

  logic        clk = 1'b0;
  logic        rst, start, stop, sample_valid;
  logic [23:0] spec_bus, impl_bus;
  logic [7:0]  tag;

  logic        busy_o [3];
  logic        done_o [3];
  logic        pass_o [3];
  logic [5:0]  mask_o [3];
  logic [15:0] sc_o   [2];
  logic [15:0] fc_o   [2];
  logic [1:0]  sc2, fc2;
  logic [2:0]  fch_o  [3];
  logic [7:0]  ftag_o [3];
  logic [3:0]  fs_o   [3];
  logic [3:0]  fi_o   [3];

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  lockstep_cmp #(.WIDTH(4), .NCH(6), .TAGW(8), .CNTW(16), .MODE(0)) u_exact (
    .clk(clk), .rst(rst), .start(start), .stop(stop), .sample_valid(sample_valid),
    .spec_bus(spec_bus), .impl_bus(impl_bus), .tag(tag),
    .busy(busy_o[0]), .done(done_o[0]), .pass(pass_o[0]), .mismatch_mask(mask_o[0]),
    .sample_cnt(sc_o[0]), .fail_cnt(fc_o[0]), .first_ch(fch_o[0]), .first_tag(ftag_o[0]),
    .first_spec(fs_o[0]), .first_impl(fi_o[0]));

  lockstep_cmp #(.WIDTH(4), .NCH(6), .TAGW(8), .CNTW(16), .MODE(1)) u_specx (
    .clk(clk), .rst(rst), .start(start), .stop(stop), .sample_valid(sample_valid),
    .spec_bus(spec_bus), .impl_bus(impl_bus), .tag(tag),
    .busy(busy_o[1]), .done(done_o[1]), .pass(pass_o[1]), .mismatch_mask(mask_o[1]),
    .sample_cnt(sc_o[1]), .fail_cnt(fc_o[1]), .first_ch(fch_o[1]), .first_tag(ftag_o[1]),
    .first_spec(fs_o[1]), .first_impl(fi_o[1]));

  lockstep_cmp #(.WIDTH(4), .NCH(6), .TAGW(8), .CNTW(2), .MODE(0)) u_sat (
    .clk(clk), .rst(rst), .start(start), .stop(stop), .sample_valid(sample_valid),
    .spec_bus(spec_bus), .impl_bus(impl_bus), .tag(tag),
    .busy(busy_o[2]), .done(done_o[2]), .pass(pass_o[2]), .mismatch_mask(mask_o[2]),
    .sample_cnt(sc2), .fail_cnt(fc2), .first_ch(fch_o[2]), .first_tag(ftag_o[2]),
    .first_spec(fs_o[2]), .first_impl(fi_o[2]));

  // Reference model: unbounded counts, clamped only when read.
  int         mode_of [3] = '{0, 1, 0};
  int         cntw_of [3] = '{16, 16, 2};
  bit         run_m   [3];
  bit         done_m  [3];
  int         samp_m  [3];
  int         fail_m  [3];
  logic [5:0] mask_m  [3];
  int         fch_m   [3];
  logic [7:0] ftag_m  [3];
  logic [3:0] fs_m    [3];
  logic [3:0] fi_m    [3];

  function automatic logic [5:0] ref_mask(int mode, logic [23:0] s, logic [23:0] m);
    logic [5:0] r;
    logic [3:0] sv, mv, care;
    r = '0;
    for (int ch = 0; ch < 6; ch++) begin
      sv = s[ch*4 +: 4];
      mv = m[ch*4 +: 4];
      if (mode == 0) begin
        r[ch] = (sv !== mv);
      end else begin
        for (int b = 0; b < 4; b++) care[b] = !$isunknown(sv[b]);
        r[ch] = ((sv & care) !== (mv & care));
      end
    end
    return r;
  endfunction

  function automatic int sat(int v, int w);
    int mx;
    mx = (1 << w) - 1;
    return (v > mx) ? mx : v;
  endfunction

  task automatic model_clear(int i);
    samp_m[i] = 0; fail_m[i] = 0; mask_m[i] = '0;
    fch_m[i] = 0; ftag_m[i] = '0; fs_m[i] = '0; fi_m[i] = '0;
  endtask

  task automatic model_step();
    logic [5:0] m;
    for (int i = 0; i < 3; i++) begin
      if (rst) begin
        run_m[i] = 0; done_m[i] = 0; model_clear(i);
      end else if (!run_m[i]) begin
        if (start) begin
          run_m[i] = 1; done_m[i] = 0; model_clear(i);
        end
      end else begin
        if (sample_valid) begin
          m = ref_mask(mode_of[i], spec_bus, impl_bus);
          samp_m[i]++;
          mask_m[i] = m;
          if (m != 0) begin
            if (fail_m[i] == 0) begin
              for (int ch = 5; ch >= 0; ch--) if (m[ch]) fch_m[i] = ch;
              ftag_m[i] = tag;
              fs_m[i]   = spec_bus[fch_m[i]*4 +: 4];
              fi_m[i]   = impl_bus[fch_m[i]*4 +: 4];
            end
            fail_m[i]++;
          end
        end
        if (stop) begin
          run_m[i] = 0; done_m[i] = 1;
        end
      end
    end
  endtask

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic check_model();
    logic [31:0] sc, fc;
    for (int i = 0; i < 3; i++) begin
      if (i == 2) begin sc = 32'(sc2); fc = 32'(fc2); end
      else        begin sc = 32'(sc_o[i]); fc = 32'(fc_o[i]); end
      chk($sformatf("u%0d.busy", i), 32'(busy_o[i]), 32'(run_m[i]));
      chk($sformatf("u%0d.done", i), 32'(done_o[i]), 32'(done_m[i]));
      chk($sformatf("u%0d.pass", i), 32'(pass_o[i]), 32'(done_m[i] && fail_m[i] == 0));
      chk($sformatf("u%0d.mask", i), 32'(mask_o[i]), 32'(mask_m[i]));
      chk($sformatf("u%0d.sample_cnt", i), sc, 32'(sat(samp_m[i], cntw_of[i])));
      chk($sformatf("u%0d.fail_cnt", i), fc, 32'(sat(fail_m[i], cntw_of[i])));
      chk($sformatf("u%0d.first_ch", i), 32'(fch_o[i]), 32'(fch_m[i]));
      chk($sformatf("u%0d.first_tag", i), 32'(ftag_o[i]), 32'(ftag_m[i]));
      chk($sformatf("u%0d.first_spec", i), 32'(fs_o[i]), 32'(fs_m[i]));
      chk($sformatf("u%0d.first_impl", i), 32'(fi_o[i]), 32'(fi_m[i]));
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
    check_model();
    start = 1'b0; stop = 1'b0; sample_valid = 1'b0;
  endtask

  typedef struct {
    bit          start, stop, sv;
    logic [23:0] spec, impl;
    logic [7:0]  tag;
    bit          busy, done, pass;
    logic [5:0]  mask;
    int          sc, fc, fch;
  } vec_t;

  vec_t tbl [10];

  initial begin
    logic [23:0] xz_word;
    logic [3:0]  xz_nib;
    tbl[0] = '{1, 0, 0, 24'h123456, 24'h123456, 8'h00, 1, 0, 0, 6'b000000, 0, 0, 0};
    tbl[1] = '{0, 0, 1, 24'h123456, 24'h123456, 8'h01, 1, 0, 0, 6'b000000, 1, 0, 0};
    tbl[2] = '{0, 0, 1, 24'h123456, 24'h123446, 8'h02, 1, 0, 0, 6'b000010, 2, 1, 1};
    tbl[3] = '{0, 0, 0, 24'h123456, 24'h123446, 8'h03, 1, 0, 0, 6'b000010, 2, 1, 1};
    tbl[4] = '{1, 0, 1, 24'h123456, 24'h123456, 8'h04, 1, 0, 0, 6'b000000, 3, 1, 1};
    tbl[5] = '{0, 1, 1, 24'h123456, 24'h92345E, 8'h05, 0, 1, 0, 6'b100001, 4, 2, 1};
    tbl[6] = '{0, 0, 1, 24'hFFFFFF, 24'h000000, 8'h06, 0, 1, 0, 6'b100001, 4, 2, 1};
    tbl[7] = '{0, 1, 0, 24'h000000, 24'h000000, 8'h07, 0, 1, 0, 6'b100001, 4, 2, 1};
    tbl[8] = '{1, 0, 0, 24'h000000, 24'h000000, 8'h08, 1, 0, 0, 6'b000000, 0, 0, 0};
    tbl[9] = '{0, 1, 0, 24'h000000, 24'h000000, 8'h09, 0, 1, 1, 6'b000000, 0, 0, 0};

    rst = 1'b1; start = 1'b0; stop = 1'b0; sample_valid = 1'b0;
    spec_bus = '0; impl_bus = '0; tag = '0;
    tick(); tick();
    chk("reset.busy", 32'(busy_o[0]), 0);
    chk("reset.done", 32'(done_o[0]), 0);
    chk("reset.sample_cnt", 32'(sc_o[0]), 0);
    rst = 1'b0;
    tick();

    // Table: ignored start in RUN, sample+stop counted, DONE holds, restart clears.
    for (int r = 0; r < 10; r++) begin
      start = tbl[r].start; stop = tbl[r].stop; sample_valid = tbl[r].sv;
      spec_bus = tbl[r].spec; impl_bus = tbl[r].impl; tag = tbl[r].tag;
      tick();
      chk($sformatf("tbl%0d.busy", r), 32'(busy_o[0]), 32'(tbl[r].busy));
      chk($sformatf("tbl%0d.done", r), 32'(done_o[0]), 32'(tbl[r].done));
      chk($sformatf("tbl%0d.pass", r), 32'(pass_o[0]), 32'(tbl[r].pass));
      chk($sformatf("tbl%0d.mask", r), 32'(mask_o[0]), 32'(tbl[r].mask));
      chk($sformatf("tbl%0d.sample_cnt", r), 32'(sc_o[0]), 32'(tbl[r].sc));
      chk($sformatf("tbl%0d.fail_cnt", r), 32'(fc_o[0]), 32'(tbl[r].fc));
      chk($sformatf("tbl%0d.first_ch", r), 32'(fch_o[0]), 32'(tbl[r].fch));
    end

    // Identical buses carrying x/z compare equal.
    xz_word = 24'b1x0z_zx10_0000_1111_xxzz_0101;
    start = 1'b1; tick();
    sample_valid = 1'b1; spec_bus = xz_word; impl_bus = xz_word; tag = 8'h40; tick();
    stop = 1'b1; tick();
    chk("xzeq.sample_cnt", 32'(sc_o[0]), 1);
    chk("xzeq.fail_cnt", 32'(fc_o[0]), 0);
    chk("xzeq.done", 32'(done_o[0]), 1);
    chk("xzeq.pass", 32'(pass_o[0]), 1);

    // Channel 2 differs only where spec holds x; channel 4 differs in known bits.
    start = 1'b1; tick();
    spec_bus = '0; impl_bus = '0;
    xz_nib = 4'b1x0z; spec_bus[11:8] = xz_nib;
    xz_nib = 4'b100z; impl_bus[11:8] = xz_nib;
    spec_bus[19:16] = 4'hA; impl_bus[19:16] = 4'h5;
    sample_valid = 1'b1; tag = 8'h15; tick();
    stop = 1'b1; tick();
    chk("multi.first_tag", 32'(ftag_o[0]), 32'h15);
    chk("multi.ch4", 32'(mask_o[0][4]), 1);

    // Same with channel 4 matching: spec-X instance must see no failure.
    start = 1'b1; tick();
    impl_bus[19:16] = 4'hA;
    sample_valid = 1'b1; tag = 8'h16; tick();
    stop = 1'b1; tick();

    // Five failing samples: 2-bit fail counter saturates at 3.
    start = 1'b1; tick();
    for (int k = 0; k < 5; k++) begin
      sample_valid = 1'b1; spec_bus = 24'hFFFFFF; impl_bus = 24'h000000; tag = 8'(8'h30 + k);
      tick();
    end
    stop = 1'b1; tick();
    chk("sat.fail_cnt", 32'(fc2), 3);
    chk("sat.sample_cnt", 32'(sc2), 3);
    chk("sat.first_tag", 32'(ftag_o[2]), 32'h30);
    chk("sat.wide_fail_cnt", 32'(fc_o[0]), 5);

    // Asynchronous reset mid-run wipes all run data before the next edge.
    start = 1'b1; tick();
    for (int k = 0; k < 2; k++) begin
      sample_valid = 1'b1; spec_bus = 24'h00000F; impl_bus = 24'h000000; tag = 8'(8'h50 + k);
      tick();
    end
    #2 rst = 1'b1;
    #1;
    chk("arst.busy", 32'(busy_o[0]), 0);
    chk("arst.done", 32'(done_o[0]), 0);
    chk("arst.pass", 32'(pass_o[0]), 0);
    chk("arst.mask", 32'(mask_o[0]), 0);
    chk("arst.sample_cnt", 32'(sc_o[0]), 0);
    chk("arst.fail_cnt", 32'(fc_o[0]), 0);
    chk("arst.first_ch", 32'(fch_o[0]), 0);
    chk("arst.first_tag", 32'(ftag_o[0]), 0);
    chk("arst.first_spec", 32'(fs_o[0]), 0);
    chk("arst.first_impl", 32'(fi_o[0]), 0);
    tick();
    rst = 1'b0;
    start = 1'b1; tick();
    stop = 1'b1; tick();
    chk("arst.rerun_pass", 32'(pass_o[0]), 1);

    // Randomized traffic against the model.
    for (int c = 0; c < 400; c++) begin
      rst          = ($urandom_range(0, 99) == 0);
      start        = ($urandom_range(0, 7) == 0);
      stop         = ($urandom_range(0, 9) == 0);
      sample_valid = $urandom_range(0, 1) == 1;
      spec_bus     = 24'($urandom);
      impl_bus     = spec_bus ^ 24'($urandom & $urandom & $urandom);
      if ($urandom_range(0, 7) == 0) spec_bus[$urandom_range(0, 23)] = 1'bx;
      tag          = 8'($urandom);
      tick();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/lockstep_cmp.md
LOCKSTEP_CMP -- requirements
Module: lockstep_cmp

Interface
REQ-001 Parameter WIDTH, default 4: bits per compared channel.
REQ-002 Parameter NCH, default 6: number of compared channels.
REQ-003 Parameter TAGW, default 8: width of the stimulus tag recorded with each sample.
REQ-004 Parameter CNTW, default 16: width of sample and failure counters.
REQ-005 Parameter MODE, default 0: 0 = exact 4-state match; 1 = spec X/Z bits are don't-care.
REQ-006 The block SHALL have one clock and an asynchronous, active-high reset.
REQ-007 clk input 1: clock; all state updates on the rising edge.
REQ-008 rst input 1: asynchronous, active-high reset.
REQ-009 start input 1: single-cycle pulse that begins a run.
REQ-010 stop input 1: single-cycle pulse that ends a run.
REQ-011 sample_valid input 1: spec_bus, impl_bus and tag are valid this cycle.
REQ-012 spec_bus input NCH*WIDTH: reference outputs; channel k occupies bits [k*WIDTH +: WIDTH].
REQ-013 impl_bus input NCH*WIDTH: implementation outputs, same packing as spec_bus.
REQ-014 tag input TAGW: stimulus identifier for the sample.
REQ-015 busy output 1: high while in RUN.
REQ-016 done output 1: high while in DONE.
REQ-017 pass output 1: valid while done; high iff fail_cnt == 0.
REQ-018 mismatch_mask output NCH: per-channel mismatch result of the last sample.
REQ-019 sample_cnt output CNTW: samples compared in the current run.
REQ-020 fail_cnt output CNTW: samples with at least one mismatching channel.
REQ-021 first_ch output clog2(NCH), first_tag output TAGW, first_spec / first_impl outputs WIDTH: capture of the first failure.

Function
REQ-022 States: IDLE, RUN, DONE.
REQ-023 IDLE->RUN on start; on entry, clear sample_cnt, fail_cnt, mismatch_mask and all first_* fields.
REQ-024 In RUN, start SHALL be ignored.
REQ-025 RUN->DONE on stop; a sample_valid in the same cycle as stop SHALL be compared and counted.
REQ-026 DONE->RUN on start, with the clearing in REQ-023; DONE otherwise holds all outputs.
REQ-027 sample_valid outside RUN SHALL be ignored; stop outside RUN SHALL be ignored.
REQ-028 MODE 0: a channel mismatches iff any bit differs under 4-state case equality; X and Z are distinct values.
REQ-029 MODE 1: a bit whose spec value is X or Z never mismatches; all other bits compare as in MODE 0.
REQ-030 mismatch_mask, sample_cnt and fail_cnt SHALL update on the edge following sample_valid, giving 1-cycle latency.
REQ-031 mismatch_mask SHALL hold its value between samples.
REQ-032 sample_cnt and fail_cnt SHALL saturate at 2^CNTW-1.
REQ-033 first_* SHALL be written only on the first failing sample of a run.
REQ-034 When several channels fail in that sample, the lowest index SHALL be captured.
REQ-035 pass SHALL be 0 whenever done is 0.
REQ-036 The DONE transition in REQ-025 SHALL occur on the same edge as the final sample's update, so counts are final when done first rises.

Reset
REQ-037 While rst is high: state IDLE, and busy, done, pass, mismatch_mask, sample_cnt, fail_cnt and all first_* outputs are 0.
REQ-038 Reset asserted mid-run SHALL abort the run with no output retaining run data.

Structure
REQ-039 Package lockstep_cmp_pkg SHALL hold the state enum and the MODE_EXACT=0 / MODE_SPECX=1 constants.
REQ-040 Per-channel compare SHALL be a sub-module lockstep_cmp_chan(WIDTH, MODE) producing a 1-bit mismatch; lockstep_cmp instantiates NCH copies.

Verification
REQ-041 MODE 0, default parameters: start, then one sample with spec_bus==impl_bus containing x/z values, then stop -> sample_cnt=1, fail_cnt=0, done=1, pass=1.
REQ-042 MODE 0: channel 2 spec=4'b1x0z, impl=4'b100z, tag=8'h15; channel 4 also mismatches in the same sample -> mismatch_mask=6'b010100, first_ch=2, first_tag=8'h15, first_spec=1x0z, first_impl=100z.
REQ-043 MODE 1, same stimulus as REQ-042 with channel 4 matching -> mismatch_mask=0, fail_cnt=0.
REQ-044 sample_valid and stop in the same cycle after 3 earlier samples -> sample_cnt=4 when done first rises; a later sample_valid in DONE leaves sample_cnt=4.
REQ-045 CNTW=2, every sample failing: 5 samples -> fail_cnt=3 (saturated); first_tag equals the first sample's tag.
REQ-046 rst pulsed mid-run after 2 failing samples -> all outputs 0 and state IDLE; a new start/stop with no samples -> pass=1.
